// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared defaults and constants for the VGA layer mixer
package vga_pkg;

  localparam int RGB_W_DEF        = 12;
  localparam int N_LAYERS_DEF     = 8;
  localparam int BLINK_FRAMES_DEF = 30;

  localparam logic [RGB_W_DEF-1:0] RGB_BLACK = '0;

endpackage

// File: rtl/vga_layer_mixer_if.sv
// rtl/vga_layer_mixer_if.sv - overlay layer bus feeding the mixer
interface vga_layer_mixer_if #(
  parameter int N_LAYERS = 8,
  parameter int RGB_W    = 12
);

  logic [N_LAYERS*RGB_W-1:0] layer_rgb;
  logic [N_LAYERS-1:0]       layer_ok;
  logic [N_LAYERS-1:0]       layer_en;
  logic [N_LAYERS-1:0]       blink_en;
  logic [RGB_W-1:0]          bg_rgb;

  modport master (
    output layer_rgb, layer_ok, layer_en, blink_en, bg_rgb
  );

  modport slave (
    input layer_rgb, layer_ok, layer_en, blink_en, bg_rgb
  );

endinterface

// File: rtl/vga_prio_mux.sv
// rtl/vga_prio_mux.sv - lowest-index-first colour select with found flag
module vga_prio_mux #(
  parameter int N_LAYERS = 8,
  parameter int RGB_W    = 12
) (
  input  logic [N_LAYERS*RGB_W-1:0] rgb_i,
  input  logic [N_LAYERS-1:0]       visible_i,
  output logic [RGB_W-1:0]          rgb_o,
  output logic                      found_o
);

  // Scan from the top so the lowest visible index is the last write and wins.
  always_comb begin
    rgb_o   = '0;
    found_o = 1'b0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (visible_i[i]) begin
        rgb_o   = rgb_i[i*RGB_W +: RGB_W];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - two-stage priority overlay compositor with frame-based blink
module vga_layer_mixer
  import vga_pkg::*;
#(
  parameter int N_LAYERS     = N_LAYERS_DEF,
  parameter int RGB_W        = RGB_W_DEF,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_tick,
  input  logic             video_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  vga_layer_mixer_if.slave lay,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on_out,
  output logic             blink_phase
);

  localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

  logic [N_LAYERS*RGB_W-1:0] s1_rgb_q;
  logic [N_LAYERS-1:0]       s1_ok_q, s1_en_q, s1_blink_q;
  logic                      s1_von_q, s1_hs_q, s1_vs_q;

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hs_q, vs_q, von_q;
  logic             vs_prev_q;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             phase_q, phase_d;

  logic [N_LAYERS-1:0] visible;
  logic [RGB_W-1:0]    sel_rgb;
  logic                sel_found;
  logic                frame_start;

  assign visible = s1_ok_q & s1_en_q & ~(s1_blink_q & {N_LAYERS{phase_q}});

  vga_prio_mux #(
    .N_LAYERS (N_LAYERS),
    .RGB_W    (RGB_W)
  ) u_prio (
    .rgb_i     (s1_rgb_q),
    .visible_i (visible),
    .rgb_o     (sel_rgb),
    .found_o   (sel_found)
  );

  // Falling edge of raw vsync between consecutive pixel samples.
  assign frame_start = vs_prev_q & ~vsync_in;

  always_comb begin
    rgb_d       = sel_found ? sel_rgb : lay.bg_rgb;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (!s1_von_q) begin
      rgb_d = RGB_W'(RGB_BLACK);
    end
    if (frame_start) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rgb_q    <= '0;
      s1_ok_q     <= '0;
      s1_en_q     <= '0;
      s1_blink_q  <= '0;
      s1_von_q    <= 1'b0;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      von_q       <= 1'b0;
      vs_prev_q   <= 1'b1;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (pixel_tick) begin
      s1_rgb_q    <= lay.layer_rgb;
      s1_ok_q     <= lay.layer_ok;
      s1_en_q     <= lay.layer_en;
      s1_blink_q  <= lay.blink_en;
      s1_von_q    <= video_on;
      s1_hs_q     <= hsync_in;
      s1_vs_q     <= vsync_in;
      rgb_q       <= rgb_d;
      hs_q        <= s1_hs_q;
      vs_q        <= s1_vs_q;
      von_q       <= s1_von_q;
      vs_prev_q   <= vsync_in;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign rgb          = rgb_q;
  assign hsync        = hs_q;
  assign vsync        = vs_q;
  assign video_on_out = von_q;
  assign blink_phase  = phase_q;

endmodule

// File: doc/vga_layer_mixer.md
VGA_LAYER_MIXER -- requirements
Module: vga_layer_mixer

Interface
REQ-001 Parameter N_LAYERS, default 8: number of overlay channels; legal range 1..16.
REQ-002 Parameter RGB_W, default 12: pixel colour width in bits.
REQ-003 Parameter BLINK_FRAMES, default 30: frames per blink half-period; legal range 1..255.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high. The ports are named clk and reset.
REQ-005 Port clk, input, 1 bit: system clock.
REQ-006 Port reset, input, 1 bit: synchronous active-high reset.
REQ-007 Port pixel_tick, input, 1 bit: pixel enable strobe from the sync generator.
REQ-008 Port video_on, input, 1 bit: active-area flag for the current pixel.
REQ-009 Port hsync_in / vsync_in, input, 1 bit each: raw active-low sync signals.
REQ-010 Port layer_rgb, input, N_LAYERS*RGB_W bits: colour of layer i in slice [i*RGB_W +: RGB_W].
REQ-011 Port layer_ok, input, N_LAYERS bits: layer i currently covers the pixel.
REQ-012 Port layer_en, input, N_LAYERS bits: layer i is globally enabled.
REQ-013 Port blink_en, input, N_LAYERS bits: layer i blinks.
REQ-014 Port bg_rgb, input, RGB_W bits: background colour.
REQ-015 Port rgb, output, RGB_W bits: composited pixel.
REQ-016 Port hsync / vsync, output, 1 bit each: syncs delayed to align with rgb.
REQ-017 Port video_on_out, output, 1 bit: delayed video_on.
REQ-018 Port blink_phase, output, 1 bit: current blink phase; 1 = blinking layers hidden.

Function
REQ-019 All state SHALL advance only on clk edges where pixel_tick=1; otherwise every register holds its value.
REQ-020 Stage 1 SHALL register layer_rgb, layer_ok, layer_en, blink_en, video_on, hsync_in and vsync_in.
REQ-021 Stage 2 SHALL form visible[i] = ok & en & ~(blink_en & blink_phase) from the stage-1 values.
- Selection is fixed priority: the lowest index with visible[i]=1 wins.
- If no layer is visible, the output is bg_rgb.
- If the stage-1 video_on=0, the output is all-zero, overriding all layers and the background.
REQ-022 Latency from input to rgb, hsync, vsync and video_on_out SHALL be exactly 2 pixel_tick strobes; the syncs SHALL pass through the same 2-stage delay.
REQ-023 A frame start is a 1->0 transition of vsync_in between consecutive pixel_tick samples (previous sampled value 1, current 0).
REQ-024 The frame counter (8 bit) SHALL increment on each frame start. On reaching BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase in the same cycle.
REQ-025 With BLINK_FRAMES=1, blink_phase SHALL toggle on every frame start.
REQ-026 A frame start coinciding with reset SHALL be ignored.
REQ-027 bg_rgb is sampled in stage 2, not delayed; a change therefore appears after 1 tick.
REQ-028 Overlapping layers SHALL never be blended (no OR or arithmetic); only the winning layer passes.

Reset
REQ-029 On reset the block SHALL clear rgb, all pipeline colour and ok registers, video_on_out, the frame counter and blink_phase to 0.
REQ-030 On reset the block SHALL set hsync, vsync, the sync pipeline and the previous-vsync register to 1 (inactive).
REQ-031 Reset asserted mid-frame SHALL take effect on the next clk edge regardless of pixel_tick.
REQ-032 After reset, the first valid output SHALL appear on the second pixel_tick.

Structure
REQ-033 A shared package vga_pkg SHALL hold the default RGB_W, the default N_LAYERS, the BLINK_FRAMES default, and the RGB_BLACK constant.
REQ-034 The priority select SHALL be a sub-module vga_prio_mux: a combinational lowest-index-first select with a found flag, parametrised on N_LAYERS and RGB_W.

Verification
REQ-035 Priority test: N=8; layers 2 and 5 ok and enabled, layer 2=12'hF00, layer 5=12'h0F0 -> rgb=12'hF00 two ticks later. With layer 2 ok dropped -> rgb=12'h0F0.
REQ-036 Background test: all ok=0, bg_rgb=12'h00F, video_on=1 -> rgb=12'h00F. Then video_on=0 -> rgb=12'h000 after 2 ticks.
REQ-037 Blink test: BLINK_FRAMES=3, layer 0 blink_en=1, 12'hFFF, ok=1; 3 vsync falling edges -> blink_phase=1 and rgb=bg_rgb. 3 more edges -> rgb=12'hFFF.
REQ-038 Tick gating test: pixel_tick held low for 10 cycles while inputs change -> rgb, hsync and vsync unchanged.
REQ-039 Sync alignment test: single-tick hsync_in low pulse -> hsync low exactly 2 ticks later for 1 tick.
REQ-040 Mid-frame reset test: reset for 1 cycle mid-line with blink_phase=1 -> next cycle rgb=0, hsync=vsync=1, blink_phase=0, frame counter=0.
